// File: rtl/osecpu_pkg.sv
// Shared definitions for the osecpu core: opcodes, ALU operations, FSM states
// and the instruction word layout.
package osecpu_pkg;

   localparam logic [7:0] OP_LIMM16 = 8'h02;
   localparam logic [7:0] OP_CP     = 8'hD2;
   localparam logic [7:0] OP_OR     = 8'h10;
   localparam logic [7:0] OP_XOR    = 8'h11;
   localparam logic [7:0] OP_AND    = 8'h12;
   localparam logic [7:0] OP_ADD    = 8'h14;
   localparam logic [7:0] OP_SUB    = 8'h15;
   localparam logic [7:0] OP_MUL    = 8'h16;
   localparam logic [7:0] OP_CPDR   = 8'hD3;
   localparam logic [7:0] OP_END    = 8'hF0;

   // ALU operation is the low nibble of the opcode for the 0x1X group.
   typedef enum logic [3:0] {
      ALU_OR  = 4'd0,
      ALU_XOR = 4'd1,
      ALU_AND = 4'd2,
      ALU_ADD = 4'd4,
      ALU_SUB = 4'd5,
      ALU_MUL = 4'd6
   } aluOp_e;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_e;

   // Register-form view of an instruction; the immediate form reuses the
   // low 16 bits of the word directly.
   typedef struct packed {
      logic [7:0] op;
      logic [5:0] a;
      logic [5:0] b;
      logic [5:0] c;
      logic [5:0] rsvd;
   } instr_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/osecpu_core_alu.sv
// Combinational ALU for the osecpu core. Arithmetic wraps modulo 2^32 and
// undefined operation codes produce zero.
module alu_unit
   import osecpu_pkg::*;
(
   input  logic [31:0] d0,
   input  logic [31:0] d1,
   input  logic [3:0]  op,
   output logic [31:0] dout
);

   // Select the result for the requested operation; zero for unused codes.
   always_comb begin
      dout = '0;
      case (op)
         ALU_OR:  dout = d0 | d1;
         ALU_XOR: dout = d0 ^ d1;
         ALU_AND: dout = d0 & d1;
         ALU_ADD: dout = d0 + d1;
         ALU_SUB: dout = d0 - d1;
         ALU_MUL: dout = d0 * d1;
         default: dout = '0;
      endcase
   end

endmodule

// File: rtl/osecpu_core_regfile.sv
// 64 x 32-bit integer register file: two asynchronous read ports and one
// synchronous write port. Reset clears every register.
module int_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  i_rdAddr0,
   input  logic [5:0]  i_rdAddr1,
   output logic [31:0] o_rdData0,
   output logic [31:0] o_rdData1,
   input  logic        i_wrEn,
   input  logic [5:0]  i_wrAddr,
   input  logic [31:0] i_wrData
);

   logic [31:0] r_regs [64];

   assign o_rdData0 = r_regs[i_rdAddr0];
   assign o_rdData1 = r_regs[i_rdAddr1];

   // Clear all registers on reset, otherwise perform the single write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_wrEn) begin
         r_regs[i_wrAddr] <= i_wrData;
      end
   end

endmodule

// File: rtl/osecpu_core.sv
// Two-state (fetch/execute) 32-bit osecpu core with an internal program ROM.
// Every instruction takes one FETCH and one EXEC clock; all architectural
// writes land on the EXEC edge. DR and pc are exported for a display wrapper.
module osecpu_core
   import osecpu_pkg::*;
#(
   parameter int    ROM_DEPTH = 256,
   parameter string ROM_INIT  = ""
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] dr,
   output logic [15:0] pc,
   output logic        halted
);

   localparam int ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

   typedef logic [31:0] romImage_t [ROM_DEPTH];

   // Builds the power-up ROM contents: the built-in demo program that leaves
   // 3 - 7 in DR and halts, with every other word cleared to NOP.
   function automatic romImage_t loadRomImage();
      romImage_t img;
      for (int i = 0; i < ROM_DEPTH; i++) begin
         img[i] = '0;
      end
      if (ROM_INIT == "") begin
         img[0 % ROM_DEPTH] = 32'h02000003;
         img[1 % ROM_DEPTH] = 32'h02040007;
         img[2 % ROM_DEPTH] = 32'h15080040;
         img[3 % ROM_DEPTH] = 32'hD20C2000;
         img[4 % ROM_DEPTH] = 32'hD3003000;
         img[5 % ROM_DEPTH] = 32'hF0000000;
      end
      return img;
   endfunction

   romImage_t r_rom = loadRomImage();

   state_e      r_state;
   state_e      w_nextState;
   logic [15:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_dr;
   logic        r_halted;

   instr_t      w_instr;
   logic [ROM_AW-1:0] w_romAddr;
   logic [31:0] w_romWord;
   logic [31:0] w_rdData0;
   logic [31:0] w_rdData1;
   logic [31:0] w_aluOut;
   logic        w_instrLoad;
   logic        w_regWe;
   logic [31:0] w_regWd;
   logic        w_drWe;
   logic        w_haltSet;

   assign w_instr   = r_instr;
   assign w_romAddr = ROM_AW'(32'(r_pc) % ROM_DEPTH);
   assign w_romWord = r_rom[w_romAddr];

   int_regfile u_regfile (
      .clk       (clk),
      .reset     (reset),
      .i_rdAddr0 (w_instr.b),
      .i_rdAddr1 (w_instr.c),
      .o_rdData0 (w_rdData0),
      .o_rdData1 (w_rdData1),
      .i_wrEn    (w_regWe),
      .i_wrAddr  (w_instr.a),
      .i_wrData  (w_regWd)
   );

   alu_unit u_alu (
      .d0   (w_rdData0),
      .d1   (w_rdData1),
      .op   (w_instr.op[3:0]),
      .dout (w_aluOut)
   );

   // Sequence fetch/execute and decode the instruction into write strobes.
   always_comb begin
      w_nextState = r_state;
      w_instrLoad = 1'b0;
      w_regWe     = 1'b0;
      w_regWd     = '0;
      w_drWe      = 1'b0;
      w_haltSet   = 1'b0;
      case (r_state)
         FETCH: begin
            if (!r_halted) begin
               w_instrLoad = 1'b1;
               w_nextState = EXEC;
            end
         end
         EXEC: begin
            w_nextState = FETCH;
            case (w_instr.op)
               OP_LIMM16: begin
                  w_regWe = 1'b1;
                  w_regWd = sext16(r_instr[15:0]);
               end
               OP_CP: begin
                  w_regWe = 1'b1;
                  w_regWd = w_rdData0;
               end
               OP_OR, OP_XOR, OP_AND, OP_ADD, OP_SUB, OP_MUL: begin
                  w_regWe = 1'b1;
                  w_regWd = w_aluOut;
               end
               OP_CPDR: w_drWe    = 1'b1;
               OP_END:  w_haltSet = 1'b1;
               default: ;
            endcase
         end
         default: w_nextState = FETCH;
      endcase
   end

   // State, pc, instruction latch, DR and halt flag; reset wins over all.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= FETCH;
         r_pc     <= '0;
         r_instr  <= '0;
         r_dr     <= '0;
         r_halted <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_instrLoad) begin
            r_instr <= w_romWord;
         end
         if (r_state == EXEC) begin
            r_pc <= r_pc + 16'd1;
         end
         if (w_drWe) begin
            r_dr <= w_rdData0;
         end
         if (w_haltSet) begin
            r_halted <= 1'b1;
         end
      end
   end

   assign dr     = r_dr;
   assign pc     = r_pc;
   assign halted = r_halted;

endmodule

// File: tb/tb_osecpu_core.sv
// Self-checking bench for osecpu_core: an instruction-level ISA model runs
// alongside the core and every observable result is compared against it.
module tb_osecpu_core;
   import osecpu_pkg::*;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] dr;
   logic [15:0] pc;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mRom [DEPTH];
   logic [31:0] mRegs [64];
   logic [31:0] mDr;
   logic [15:0] mPc;
   logic        mHalted;

   logic [31:0] progQ [$];
   logic [31:0] expDrQ [$];

   osecpu_core #(.ROM_DEPTH(DEPTH), .ROM_INIT("")) dut (
      .clk    (clk),
      .reset  (reset),
      .dr     (dr),
      .pc     (pc),
      .halted (halted)
   );

   // Free-running 100 MHz-style clock.
   always #5 clk = ~clk;

   // Hard time limit so a stuck run still ends with a visible failure.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] encR(input logic [7:0] op, input int a, input int b, input int c);
      return {op, 6'(a), 6'(b), 6'(c), 6'b0};
   endfunction

   function automatic logic [31:0] encL(input int a, input logic [15:0] imm);
      return {8'h02, 6'(a), 2'b00, imm};
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 64; i++) mRegs[i] = '0;
      mDr     = '0;
      mPc     = '0;
      mHalted = 1'b0;
   endtask

   // One whole instruction, as the programmer's manual describes it.
   task automatic modelStep(input logic [31:0] word);
      logic [7:0]  op;
      logic [31:0] rb, rc;
      op = word[31:24];
      rb = mRegs[word[17:12]];
      rc = mRegs[word[11:6]];
      case (op)
         8'h02: mRegs[word[23:18]] = {{16{word[15]}}, word[15:0]};
         8'hD2: mRegs[word[23:18]] = rb;
         8'h10: mRegs[word[23:18]] = rb | rc;
         8'h11: mRegs[word[23:18]] = rb ^ rc;
         8'h12: mRegs[word[23:18]] = rb & rc;
         8'h14: mRegs[word[23:18]] = rb + rc;
         8'h15: mRegs[word[23:18]] = rb - rc;
         8'h16: mRegs[word[23:18]] = rb * rc;
         8'hD3: mDr = rb;
         8'hF0: mHalted = 1'b1;
         default: ;
      endcase
      mPc = mPc + 16'd1;
   endtask

   // Copy progQ into the model ROM and, optionally, into the core's ROM.
   task automatic loadProgram(input bit writeDut);
      logic [31:0] w;
      for (int i = 0; i < DEPTH; i++) begin
         w = (i < progQ.size()) ? progQ[i] : 32'h0;
         mRom[i] = w;
         if (writeDut) dut.r_rom[i] = w;
      end
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      modelReset();
   endtask

   task automatic checkRegs(input string tag);
      int bad = 0;
      for (int i = 0; i < 64; i++) begin
         if (dut.u_regfile.r_regs[i] !== mRegs[i]) bad++;
      end
      checkOutput(tag, 32'(bad), 32'd0);
   endtask

   // Run nInstr instruction slots (2 clocks each), checking after every one.
   task automatic applyStimulus(input int nInstr);
      logic [31:0] word;
      for (int k = 0; k < nInstr; k++) begin
         if (mHalted) begin
            tick(2);
         end else begin
            word = mRom[int'(mPc) % DEPTH];
            tick(1);
            checkOutput("fetchPc", 32'(pc), 32'(mPc));
            tick(1);
            modelStep(word);
            if (word[31:24] == 8'hD3 && expDrQ.size() > 0)
               checkOutput("drConst", dr, expDrQ.pop_front());
         end
         checkOutput("pc", 32'(pc), 32'(mPc));
         checkOutput("dr", dr, mDr);
         checkOutput("halted", 32'(halted), 32'(mHalted));
      end
   endtask

   initial begin
      logic [7:0]  opTab [12];
      logic [31:0] rnd;
      int          idx;

      opTab = '{8'h02, 8'hD2, 8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h16,
                8'hD3, 8'h00, 8'h13, 8'hF0};

      // Default program lives in the core already; mirror it in the model.
      progQ = '{32'h02000003, 32'h02040007, 32'h15080040,
                32'hD20C2000, 32'hD3003000, 32'hF0000000};
      loadProgram(1'b0);

      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      modelReset();
      checkOutput("rstPc", 32'(pc), 32'h0);
      checkOutput("rstDr", dr, 32'h0);
      checkOutput("rstHalted", 32'(halted), 32'h0);
      checkOutput("rstState", 32'(dut.r_state), 32'(FETCH));
      checkRegs("rstRegs");

      // Default program: 12 clocks to completion.
      applyStimulus(6);
      checkOutput("defPc", 32'(pc), 32'h6);
      checkOutput("defDr", dr, 32'hFFFFFFFC);
      checkOutput("defHalted", 32'(halted), 32'h1);
      checkRegs("defRegs");

      // Halt hold for 10 clocks.
      tick(10);
      checkOutput("holdPc", 32'(pc), 32'h6);
      checkOutput("holdDr", dr, 32'hFFFFFFFC);
      checkOutput("holdHalted", 32'(halted), 32'h1);

      // Reset during EXEC of instruction 2, then rerun to completion.
      pulseReset();
      applyStimulus(2);
      tick(1);
      reset = 1'b1;
      tick(1);
      modelReset();
      checkOutput("midRstPc", 32'(pc), 32'h0);
      checkOutput("midRstDr", dr, 32'h0);
      checkOutput("midRstHalted", 32'(halted), 32'h0);
      checkOutput("midRstState", 32'(dut.r_state), 32'(FETCH));
      checkRegs("midRstRegs");
      reset = 1'b0;
      applyStimulus(6);
      checkOutput("rerunPc", 32'(pc), 32'h6);
      checkOutput("rerunDr", dr, 32'hFFFFFFFC);
      checkOutput("rerunHalted", 32'(halted), 32'h1);

      // Sign extension of the 16-bit immediate.
      progQ = '{encL(5, 16'h8000), encR(8'hD3, 0, 5, 0),
                encL(6, 16'h7FFF), encR(8'hD3, 0, 6, 0)};
      expDrQ = '{32'hFFFF8000, 32'h00007FFF};
      loadProgram(1'b1);
      pulseReset();
      applyStimulus(4);
      checkOutput("sextLeft", 32'(expDrQ.size()), 32'd0);
      checkRegs("sextRegs");

      // ALU coverage, including wrap cases and A == B.
      progQ = '{encL(0, 16'h0F0F), encL(1, 16'h00FF),
                encR(8'h10, 2, 0, 1), encR(8'hD3, 0, 2, 0),
                encR(8'h11, 3, 0, 1), encR(8'hD3, 0, 3, 0),
                encR(8'h12, 4, 0, 1), encR(8'hD3, 0, 4, 0),
                encL(7, 16'h0001), encL(9, 16'h8000),
                encR(8'h16, 10, 9, 9), encR(8'h14, 11, 10, 10),
                encR(8'h15, 12, 11, 7), encR(8'h14, 13, 12, 7),
                encR(8'hD3, 0, 13, 0),
                encL(14, 16'h0000), encR(8'h15, 15, 14, 7), encR(8'hD3, 0, 15, 0),
                encL(16, 16'h0003), encL(17, 16'hFFFC),
                encR(8'h16, 18, 16, 17), encR(8'hD3, 0, 18, 0),
                encR(8'hD2, 19, 18, 0), encR(8'h14, 19, 19, 19), encR(8'hD3, 0, 19, 0),
                32'hF0000000};
      expDrQ = '{32'h00000FFF, 32'h00000FF0, 32'h0000000F, 32'h80000000,
                 32'hFFFFFFFF, 32'hFFFFFFF4, 32'hFFFFFFE8};
      loadProgram(1'b1);
      pulseReset();
      applyStimulus(28);
      checkOutput("aluLeft", 32'(expDrQ.size()), 32'd0);
      checkOutput("aluHalted", 32'(halted), 32'h1);
      checkOutput("aluPc", 32'(pc), 32'd26);
      checkRegs("aluRegs");

      // NOPs and unassigned opcodes leave state alone but still advance pc.
      progQ = '{encL(1, 16'h1234), encR(8'hD3, 0, 1, 0), 32'h00000000,
                encR(8'h13, 1, 1, 1), encR(8'h77, 1, 0, 0), 32'h00000000};
      expDrQ = '{32'h00001234};
      loadProgram(1'b1);
      pulseReset();
      applyStimulus(8);
      checkOutput("nopPc", 32'(pc), 32'd8);
      checkOutput("nopDr", dr, 32'h00001234);
      checkRegs("nopRegs");

      // Randomized programs against the model.
      for (int round = 0; round < 4; round++) begin
         progQ.delete();
         for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 11);
            if (idx == 11 && $urandom_range(0, 3) != 0) idx = 9;
            rnd = $urandom();
            progQ.push_back({opTab[idx], rnd[23:0]});
         end
         expDrQ.delete();
         loadProgram(1'b1);
         pulseReset();
         applyStimulus(46);
         checkRegs("rndRegs");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
